imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the CPU memory image. Fetch reads instruction bytes; this block fills that memory first.
//   Accepts a little-endian byte stream (valid/ready), packs it into 64-bit words and writes them sequentially from word 0.
//   Holds the pipeline in reset until the image is fully written. Drives the F/D/E/M/W bubble-on-reset path via cpu_rst_n_o.
// PARAMETERS
//   ADDR_W   10     word-address width of the memory write port
//   DEPTH    1024   number of 64-bit words writable (DEPTH <= 2**ADDR_W)
// PORTS
//   clk_i          in   1       clock, all logic on posedge
//   rst_i          in   1       synchronous reset, active-high
//   start_i        in   1       begin/re-arm a load (level sampled each cycle)
//   s_valid_i      in   1       stream byte valid
//   s_data_i       in   8       stream byte
//   s_last_i       in   1       marks final byte of image (qualified by valid&ready)
//   s_ready_o      out  1       loader accepts a byte this cycle
//   mem_we_o       out  1       one-cycle word write strobe
//   mem_addr_o     out  ADDR_W  word address of write
//   mem_wdata_o    out  64      packed word, byte 0 in bits [7:0]
//   cpu_rst_n_o    out  1       0 = hold pipeline in reset/bubble; 1 = run
//   done_o         out  1       image fully written
//   err_o          out  1       sticky: bytes arrived beyond DEPTH words
//   csum_o         out  8       (IMEM_LOADER_CSUM_EN only) running byte sum
// BEHAVIOUR
//   Reset (rst_i=1 at posedge): state=IDLE; s_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0,
//     cpu_rst_n_o=0, done_o=0, err_o=0, csum_o=0; byte counter, word index, pack register cleared.
//   States: IDLE -> LOAD -> FLUSH -> DONE -> (start_i) LOAD.
//   IDLE: start_i=1 -> LOAD; clears word index, lane, pack reg, err_o, csum.
//   LOAD: s_ready_o=1 (decoded from state, not registered). Handshake = s_valid_i & s_ready_o.
//     Byte stored in lane = byte_cnt[2:0] of pack reg; lane increments mod 8.
//     On handshake with lane==7 or s_last_i: next cycle mem_we_o=1, mem_addr_o=word index,
//       mem_wdata_o=pack reg incl. this byte, lanes above current forced 0; word index +1; pack reg cleared.
//     Write latency: exactly 1 cycle after the completing handshake; mem_we_o high for exactly 1 cycle.
//     Handshake with s_last_i=1 -> FLUSH. start_i ignored in LOAD.
//     Overflow: handshake when word index == DEPTH -> byte dropped, no write, err_o<=1 (sticky until next start).
//       Stream still consumed until s_last_i; last byte in overflow -> FLUSH with no write.
//   FLUSH: s_ready_o=0; final write (if any) visible on mem_we_o this cycle; -> DONE.
//   DONE: done_o=1, cpu_rst_n_o=1 (both registered, first high 2 cycles after last handshake); s_ready_o=0.
//     start_i=1 -> LOAD; done_o and cpu_rst_n_o drop to 0 on the same edge; word index restarts at 0.
//   start_i in FLUSH: ignored. s_last_i with s_valid_i=0: ignored.
//   Zero-length image impossible (s_last_i rides a real byte). A 1-byte image writes {56'h0, byte} to word 0.
//   rst_i mid-LOAD: partial word discarded, no write issued, all outputs to reset values next cycle.
//   mem_addr_o/mem_wdata_o hold last written values when mem_we_o=0.
// CONFIGURATION
//   IMEM_LOADER_CSUM_EN defined: csum_o = 8-bit mod-256 sum of all accepted bytes since start.
//     Includes dropped overflow bytes. Updates the cycle after each handshake. Cleared on start/reset.
//   Undefined: csum_o port absent; no checksum logic.
// TESTING
//   T1 reset: rst_i=1 two cycles -> all outputs 0, s_ready_o=0, cpu_rst_n_o=0.
//   T2 16 bytes 0x00..0x0F, valid every cycle ->
//      write addr0 = 64'h0706050403020100 one cycle after byte 7.
//      write addr1 = 64'h0F0E0D0C0B0A0908; done_o=1 two cycles after byte 15.
//   T3 3 bytes 0x10,0x30,0x00 (last) -> single write addr0 = 64'h0000000000003010; done_o, cpu_rst_n_o=1.
//   T4 DEPTH=2, 20 bytes, valid gaps/random stalls -> exactly 2 writes.
//      err_o=1 after byte 16; all 20 bytes accepted; DONE reached.
//   T5 rst_i asserted after byte 5 of 8 -> no mem_we_o; reload 8 bytes 0xAA -> addr0 = 64'hAAAAAAAAAAAAAAAA.
//   T6 (CSUM_EN) bytes 0xFF,0x02 (last) -> csum_o=8'h01.
//      Then start_i in DONE -> cpu_rst_n_o=0 next cycle, csum_o=0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream to 64-bit word loader for the instruction memory image.
// Optional running checksum output enabled by IMEM_LOADER_CSUM_EN.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o
`ifdef IMEM_LOADER_CSUM_EN
  ,
  output logic [7:0]        csum_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_lane;
  logic [63:0]         r_pack;
  logic [ADDR_W:0]     r_widx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [63:0]         r_wdata;
  logic                r_done;
  logic                r_run;
  logic                r_err;

  logic                w_hs;
  logic                w_start;
  logic                w_ovf;
  logic                w_wr;
  logic [5:0]          w_sh;
  logic [63:0]         w_packed;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    s_ready_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_LOAD;
      end
      S_LOAD: begin
        s_ready_o = 1'b1;
        if (s_valid_i && s_last_i) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (start_i) w_next = S_LOAD;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_hs     = s_valid_i & s_ready_o;
  assign w_start  = start_i &
                    ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_ovf    = (r_widx >= LP_DEPTH);
  assign w_wr     = w_hs & ~w_ovf &
                    ((r_lane == 3'd7) | s_last_i);
  assign w_sh     = {r_lane, 3'b000};
  assign w_packed = r_pack | (64'(s_data_i) << w_sh);

  // Pack register is cleared after each word, so upper lanes stay zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lane  <= '0;
      r_pack  <= '0;
      r_widx  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_run   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_lane <= '0;
        r_pack <= '0;
        r_widx <= '0;
        r_err  <= 1'b0;
        r_done <= 1'b0;
        r_run  <= 1'b0;
      end else if (w_hs) begin
        if (w_ovf) begin
          r_err <= 1'b1;
        end else if (w_wr) begin
          r_we    <= 1'b1;
          r_addr  <= r_widx[ADDR_W-1:0];
          r_wdata <= w_packed;
          r_widx  <= r_widx + 1'b1;
          r_pack  <= '0;
          r_lane  <= '0;
        end else begin
          r_pack <= w_packed;
          r_lane <= r_lane + 3'd1;
        end
      end else if (r_state == S_FLUSH) begin
        r_done <= 1'b1;
        r_run  <= 1'b1;
      end
    end
  end

  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign done_o      = r_done;
  assign cpu_rst_n_o = r_run;
  assign err_o       = r_err;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] r_csum;

  // Dropped overflow bytes are still summed.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_start) r_csum <= '0;
    else if (w_hs)        r_csum <= r_csum + s_data_i;
  end

  assign csum_o = r_csum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes,
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int AW = 10;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sv;
  logic [7:0]    sd;
  logic          sl;
  logic          s_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [63:0]   mem_wdata_o;
  logic          cpu_rst_n_o;
  logic          done_o;
  logic          err_o;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    csum_o;
`endif

  imem_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .s_valid_i   (sv),
    .s_data_i    (sd),
    .s_last_i    (sl),
    .s_ready_o   (s_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .done_o      (done_o),
`ifdef IMEM_LOADER_CSUM_EN
    .err_o       (err_o),
    .csum_o      (csum_o)
`else
    .err_o       (err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
    int            c;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      nwr++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_wr got addr=%0d data=%h want=none",
                 mem_addr_o, mem_wdata_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(mem_addr_o), 64'(e.a));
        chk("wr_data", mem_wdata_o, e.d);
        chk("wr_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic push(input logic [AW-1:0] a,
                      input logic [63:0] d,
                      input int c);
    exp_t e;
    e.a = a;
    e.d = d;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic last,
                      input int gap, output int hc);
    sv = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    sv = 1'b1;
    sd = b;
    sl = last;
    hc = -1;
    for (int k = 0; k < 40; k++) begin
      logic rdy;
      rdy = s_ready_o;
      @(posedge clk);
      #1;
      if (rdy) begin
        hc = cyc;
        break;
      end
    end
    sv = 1'b0;
    sl = 1'b0;
    if (hc < 0) begin
      total++;
      bad++;
      $display("FAIL hs_timeout got=none want=accept byte=%h", b);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_done(input string nm);
    chk({nm, "_flush_done"}, 64'(done_o), 64'd0);
    chk({nm, "_flush_rdy"}, 64'(s_ready_o), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, "_done"}, 64'(done_o), 64'd1);
    chk({nm, "_run"}, 64'(cpu_rst_n_o), 64'd1);
    chk({nm, "_done_rdy"}, 64'(s_ready_o), 64'd0);
  endtask

  int hc;
  int w0;
  int gaps[20] = '{0, 1, 0, 2, 0, 0, 3, 1, 0, 2,
                   1, 0, 0, 2, 0, 1, 0, 3, 0, 1};

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sv    = 1'b0;
    sl    = 1'b0;
    sd    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    // T1 reset
    chk("rst_ready", 64'(s_ready_o), 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    chk("rst_run", 64'(cpu_rst_n_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
`ifdef IMEM_LOADER_CSUM_EN
    chk("rst_csum", 64'(csum_o), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(s_ready_o), 64'd0);

    // T2 two full words
    do_start();
    chk("t2_ready", 64'(s_ready_o), 64'd1);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), (i == 15), 0, hc);
      if (i == 7)  push(0, 64'h0706050403020100, hc);
      if (i == 15) push(1, 64'h0F0E0D0C0B0A0908, hc);
    end
    check_done("t2");

    // T3 short image, restart from DONE
    do_start();
    chk("t3_start_run", 64'(cpu_rst_n_o), 64'd0);
    chk("t3_start_done", 64'(done_o), 64'd0);
    send(8'h10, 1'b0, 0, hc);
    send(8'h30, 1'b0, 1, hc);
    send(8'h00, 1'b1, 0, hc);
    push(0, 64'h0000000000003010, hc);
    check_done("t3");

    // T4 overflow past DEPTH words with stalls
    do_start();
    w0 = nwr;
    for (int i = 0; i < 20; i++) begin
      send(8'(i), (i == 19), gaps[i], hc);
      if (i == 7)  push(0, 64'h0706050403020100, hc);
      if (i == 15) push(1, 64'h0F0E0D0C0B0A0908, hc);
      if (i == 15) chk("t4_err_pre", 64'(err_o), 64'd0);
      if (i == 16) chk("t4_err_set", 64'(err_o), 64'd1);
    end
    check_done("t4");
    chk("t4_err_sticky", 64'(err_o), 64'd1);
    chk("t4_nwr", 64'(nwr - w0), 64'd2);

    // T5 reset mid-load then reload
    do_start();
    chk("t5_err_clr", 64'(err_o), 64'd0);
    w0 = nwr;
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0, 0, hc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_rst_we", 64'(mem_we_o), 64'd0);
    chk("t5_rst_ready", 64'(s_ready_o), 64'd0);
    chk("t5_rst_addr", 64'(mem_addr_o), 64'd0);
    chk("t5_rst_wdata", mem_wdata_o, 64'd0);
    chk("t5_rst_run", 64'(cpu_rst_n_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_wr", 64'(nwr - w0), 64'd0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      send(8'hAA, (i == 7), 0, hc);
    end
    push(0, 64'hAAAAAAAAAAAAAAAA, hc);
    check_done("t5");

`ifdef IMEM_LOADER_CSUM_EN
    // T6 checksum wraps mod 256
    do_start();
    chk("t6_csum_clr", 64'(csum_o), 64'd0);
    send(8'hFF, 1'b0, 0, hc);
    chk("t6_csum_b0", 64'(csum_o), 64'hFF);
    send(8'h02, 1'b1, 0, hc);
    push(0, 64'h00000000000002FF, hc);
    chk("t6_csum", 64'(csum_o), 64'h01);
    check_done("t6");
    do_start();
    chk("t6_rearm_run", 64'(cpu_rst_n_o), 64'd0);
    chk("t6_rearm_csum", 64'(csum_o), 64'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("q_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
